// File: rtl/snn_ff_pkg.sv
// Shared types for the post-neuron state SRAM arbiter: requester IDs and FSM states.
package snn_ff_pkg;

    // Requester identity; also the bit position of each requester in the arbiter vectors
    typedef enum logic {
        REQ_ENG  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_e;

    // Arbiter ownership state
    typedef enum logic {
        ST_FREE       = 1'b0,
        ST_ENG_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/post_neuron_rr_arb2.sv
// Two-way round-robin arbiter with a per-requester mask. One-bit pointer
// selects the favoured side on contention and flips away from each winner.
module post_neuron_rr_arb2
    import snn_ff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] elig;
    req_id_e    ptr_q;
    req_id_e    ptr_d;

    assign elig = req & ~mask;

    // Grant the lone eligible requester, or the favoured side when both compete
    always_comb begin
        gnt = 2'b00;
        if (elig == 2'b11) begin
            gnt[ptr_q] = 1'b1;
        end else begin
            gnt = elig;
        end
    end

    // After any grant, favour the side that did not win
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[REQ_ENG]) begin
            ptr_d = REQ_HOST;
        end else if (gnt[REQ_HOST]) begin
            ptr_d = REQ_ENG;
        end
    end

    // Pointer register; favours the engine out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= REQ_ENG;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/post_neuron_mem_arbiter.sv
// Shares the single-port post-neuron state SRAM between the neuron update
// engine and the host config port. The engine may lock the SRAM for an atomic
// read-modify-write; a watchdog breaks a lock held too long and flags it.
module post_neuron_mem_arbiter
    import snn_ff_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  eng_req,
    input  logic                  eng_we,
    input  logic [ADDR_WIDTH-1:0] eng_addr,
    input  logic [DATA_WIDTH-1:0] eng_wdata,
    input  logic                  eng_lock,
    output logic                  eng_gnt,
    output logic                  eng_rvalid,
    output logic [DATA_WIDTH-1:0] eng_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  lock_err
);

    localparam int              CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_err_q, lock_err_d;
    logic             armed_q, armed_d;
    logic             rd_pend_q, rd_pend_d;
    req_id_e          rd_owner_q, rd_owner_d;
    logic [1:0]       arb_req;
    logic [1:0]       arb_mask;
    logic [1:0]       arb_gnt;

    // Requests are suppressed while reset is held so no access leaks out
    assign arb_req  = {host_req, eng_req} & {2{~RST}};
    // The host is shut out for the whole time the engine owns the lock
    assign arb_mask = {state_q == ST_ENG_LOCKED, 1'b0};

    post_neuron_rr_arb2 u_arb (
        .clk  (CLK),
        .rst  (RST),
        .req  (arb_req),
        .mask (arb_mask),
        .gnt  (arb_gnt)
    );

    assign eng_gnt  = arb_gnt[REQ_ENG];
    assign host_gnt = arb_gnt[REQ_HOST];
    assign sram_cs  = eng_gnt | host_gnt;

    // Steer the granted requester onto the SRAM pins
    always_comb begin
        sram_we = eng_gnt & eng_we;
        sram_a  = eng_addr;
        sram_d  = eng_wdata;
        if (host_gnt) begin
            sram_we = host_we;
            sram_a  = host_addr;
            sram_d  = host_wdata;
        end
    end

    // Lock FSM next state, watchdog counter, sticky error and rearm flag
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_err_d = lock_err_q;
        armed_d    = armed_q | ~eng_lock;
        case (state_q)
            ST_FREE: begin
                if (eng_gnt && !eng_we && eng_lock && armed_q) begin
                    state_d = ST_ENG_LOCKED;
                    cnt_d   = '0;
                end
            end
            ST_ENG_LOCKED: begin
                if (!eng_lock) begin
                    state_d = ST_FREE;
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog: force release and ignore eng_lock until it drops
                    state_d    = ST_FREE;
                    lock_err_d = 1'b1;
                    armed_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    // Lock FSM registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_FREE;
            cnt_q      <= '0;
            lock_err_q <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_err_q <= lock_err_d;
            armed_q    <= armed_d;
        end
    end

    // Remember whether a read was issued this cycle and on whose behalf
    always_comb begin
        rd_pend_d  = sram_cs & ~sram_we;
        rd_owner_d = host_gnt ? REQ_HOST : REQ_ENG;
    end

    // Read-return tracking; reset drops any read still in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_ENG;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign eng_rvalid  = rd_pend_q & (rd_owner_q == REQ_ENG);
    assign host_rvalid = rd_pend_q & (rd_owner_q == REQ_HOST);
    assign eng_rdata   = sram_q;
    assign host_rdata  = sram_q;
    assign lock_err    = lock_err_q;

endmodule
